// File: rtl/custom_clk_div_pkg.sv
// custom_clk_div_pkg: shared divider width and the project's named strobe periods
package custom_clk_div_pkg;
  localparam int CLK_DIV_WIDTH = 26;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_22HZ = 26'd2_272_727;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_77HZ = 26'd649_350;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_40HZ = 26'd1_250_000;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_69HZ = 26'd724_637;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_57HZ = 26'd877_192;
  localparam logic [CLK_DIV_WIDTH-1:0] PERIOD_56HZ = 26'd892_857;
endpackage

// File: rtl/custom_clk_div.sv
// custom_clk_div: one-cycle strobe every `period` clocks, period resampled only at terminal count
module custom_clk_div
  import custom_clk_div_pkg::*;
#(
  parameter int WIDTH = CLK_DIV_WIDTH
) (
  input  logic             resetn,
  input  logic             sixtyhz_clk,
  input  logic [WIDTH-1:0] period,
  output logic             pulse_out
);
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] term;
  // A zero period behaves as one, so the terminal count is never below zero
  assign term = (period_q == '0) ? '0 : period_q - 1'b1;
  // Count up to the terminal value, strobe there and latch the next period
  always_ff @(posedge sixtyhz_clk) begin
    if (!resetn) begin
      count     <= '0;
      pulse_out <= 1'b0;
      period_q  <= period;
    end else if (count == term) begin
      count     <= '0;
      pulse_out <= 1'b1;
      period_q  <= period;
    end else begin
      count     <= count + 1'b1;
      pulse_out <= 1'b0;
    end
  end
`ifndef SYNTHESIS
  // The counter must never run past the active period
  always_ff @(posedge sixtyhz_clk) if (resetn) assert (count <= term);
`endif
endmodule

// File: tb/tb_custom_clk_div.sv
// tb_custom_clk_div: directed checks of strobe timing, period resampling, reset abort and full-width terminal
module tb_custom_clk_div;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [25:0] period = 26'd4;
  logic        pulse;
  logic        resetn8 = 1'b0;
  logic [7:0]  period8 = 8'd255;
  logic        pulse8;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  custom_clk_div dut (
    .resetn(resetn),
    .sixtyhz_clk(clk),
    .period(period),
    .pulse_out(pulse)
  );

  custom_clk_div #(.WIDTH(8)) dut8 (
    .resetn(resetn8),
    .sixtyhz_clk(clk),
    .period(period8),
    .pulse_out(pulse8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic [25:0] p);
    resetn = 1'b0;
    period = p;
    tick();
    tick();
    check("reset_pulse", {31'd0, pulse}, 32'd0);
    check("reset_count", {6'd0, dut.count}, 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    int last;
    int strobes;
    int doubles;
    logic prev;
    // period 4: strobes at edges 4, 8, 12, low during reset
    tick();
    check("rst_p4_a", {31'd0, pulse}, 32'd0);
    hold_reset(26'd4);
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("p4_e%0d", e), {31'd0, pulse}, (e % 4 == 0) ? 32'd1 : 32'd0);
    end
    // period 1 and period 0: high on every edge after release
    hold_reset(26'd1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("p1_e%0d", e), {31'd0, pulse}, 32'd1);
    end
    hold_reset(26'd0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("p0_e%0d", e), {31'd0, pulse}, 32'd1);
    end
    // period 5 changed to 3 after edge 2: strobes at 5, 8, 11
    hold_reset(26'd5);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 2) period = 26'd3;
      check($sformatf("p53_e%0d", e), {31'd0, pulse}, (e == 5 || e == 8 || e == 11) ? 32'd1 : 32'd0);
    end
    // period 6 aborted by reset at edge 4, next strobe six edges after release
    hold_reset(26'd6);
    for (int e = 1; e <= 3; e++) tick();
    resetn = 1'b0;
    tick();
    check("abort_pulse", {31'd0, pulse}, 32'd0);
    check("abort_count", {6'd0, dut.count}, 32'd0);
    resetn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("p6_e%0d", e), {31'd0, pulse}, (e == 6) ? 32'd1 : 32'd0);
    end
    // period 1000 over 10000 edges: ten single-cycle strobes 1000 apart
    hold_reset(26'd1000);
    last = 0;
    strobes = 0;
    doubles = 0;
    prev = 1'b0;
    for (int e = 1; e <= 10000; e++) begin
      tick();
      if (pulse) begin
        check("p1000_gap", e - last, 32'd1000);
        last = e;
        strobes++;
        if (prev) doubles++;
      end
      prev = pulse;
    end
    check("p1000_count", strobes, 32'd10);
    check("p1000_wide", doubles, 32'd0);
    // 8-bit variant at full-scale period 255: count reaches 254 without wrapping
    tick();
    tick();
    resetn8 = 1'b1;
    for (int e = 1; e <= 254; e++) tick();
    check("w8_count_254", {24'd0, dut8.count}, 32'd254);
    check("w8_pulse_254", {31'd0, pulse8}, 32'd0);
    tick();
    check("w8_count_255", {24'd0, dut8.count}, 32'd0);
    check("w8_pulse_255", {31'd0, pulse8}, 32'd1);
    tick();
    check("w8_count_256", {24'd0, dut8.count}, 32'd1);
    check("w8_pulse_256", {31'd0, pulse8}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/custom_clk_div.md
# custom_clk_div

Programmable rate-pulse generator. It divides the input clock by a 26-bit run-time period and emits a single-cycle strobe once every `period` clock cycles. Several instances, each with a different constant period, sit beside the ball/paddle logic and supply the x/y step strobes that set the ball's trajectory angle.

## Interface
Parameters:
- `WIDTH`, default 26: width of the period input and the internal counter.

Ports (positional order is as listed):
- `resetn`, input, 1: synchronous, active-low reset. Tied to 1 when no reset is needed.
- `sixtyhz_clk`, input, 1: clock. All logic updates on its rising edge.
- `period`, input, WIDTH: number of clock cycles between strobes. Unsigned.
- `pulse_out`, output, 1: registered strobe, high for exactly one cycle per period.

## Operation
- Internal state:
  - `count`, WIDTH bits: cycles elapsed in the current period.
  - `period_q`, WIDTH bits: the active period.
- Effective period `P = (period_q == 0) ? 1 : period_q`. A value of 0 behaves as 1.
- Reset (`resetn == 0` at a rising edge):
  - `count <= 0`
  - `pulse_out <= 0`
  - `period_q <= period`
  - Reset takes priority over all other behaviour, including mid-period.
- Normal edge when `count == P-1` (terminal):
  - `count <= 0`
  - `pulse_out <= 1`
  - `period_q <= period`, so a new period is sampled only at this point.
- Normal edge otherwise:
  - `count <= count + 1`
  - `pulse_out <= 0`
- Changes to `period` between terminal edges do not affect the period in progress. They take effect in the period that starts at the next terminal edge.
- Counter width rule: `count` never exceeds `P-1`, so it never wraps, even at `period = 2^WIDTH-1`.
- When `P == 1`, every edge is terminal and `pulse_out` stays high continuously from the first post-reset edge.

## Timing
- Reset value of `pulse_out` is 0. `pulse_out` has no combinational path from any input.
- Edges are numbered 1, 2, … after `resetn` goes high.
  - First strobe: `pulse_out` rises at edge P and falls at edge P+1 (for P > 1).
  - Subsequent strobes: at edges 2P, 3P, and so on.
- Strobe duty: 1 cycle high, P-1 cycles low.
- Rate: f_clk / P. For example, 50 MHz with P = 2_272_727 gives about 22 Hz.
- A period update applied before terminal edge k·P yields the next strobe at k·P + P_new.

## Structure
- Single flat module. No sub-modules needed.
- The shared package holds:
  - `CLK_DIV_WIDTH = 26`
  - the project's named period constants: 2_272_727, 649_350, 1_250_000, 724_637, 877_192, 892_857.
- Optional `assert` on `count < P`, guarded for simulation only.

## Test plan
- Reset released, `period = 4`: `pulse_out` is 1 only during the cycles after edges 4, 8, 12. It is 0 at every other cycle, including all cycles while reset is held.
- `period = 1`, and separately `period = 0`: `pulse_out` is 0 during reset, then 1 on every cycle from edge 1 onward.
- `period = 5`, changed to 3 at edge 2: strobes at edges 5, 8, 11. No strobe at edge 3.
- `period = 6`, `resetn` pulsed low at edge 4: `pulse_out` is 0 and `count` is 0. The next strobe comes 6 edges after release; no early strobe from the aborted count.
- `period = 1000`, run 10_000 edges: exactly 10 strobes, each one cycle wide, spaced exactly 1000 apart.
- `period = 2^26-1`: `count` reaches 2^26-2, then the strobe fires and `count` returns to 0. No wrap and no missed strobe. Use forced-state or a reduced `WIDTH = 8` variant with `period = 255`.
